// File: rtl/seq_mag_comp.sv
// Multi-cycle MSB-first magnitude comparator: DIGIT bits per cycle, early exit on
// the first differing digit, unsigned or two's-complement, with start/ready/done/abort.
module seq_mag_comp #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             ready,
    output logic             done,
    output logic             EQ,
    output logic             GT,
    output logic             LT
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0]    CNT_LAST = CW'(N - 1);
    localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]    CNT_ZERO = CW'(0);
    localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // One link of the cascaded digit chain: {equal, greater}.
    function automatic logic [1:0] digit_cmp(input logic [DIGIT-1:0] a,
                                             input logic [DIGIT-1:0] b);
        return {(a == b), (a > b)};
    endfunction

    state_t            state_r, state_s;
    logic [CW-1:0]     cnt_r, cnt_s;
    logic [WIDTH-1:0]  a_r, a_s, b_r, b_s;
    logic              ready_r, ready_s;
    logic              done_r, done_s;
    logic              eq_r, eq_s, gt_r, gt_s, lt_r, lt_s;
    logic [1:0]        dig_s;
    logic [WIDTH-1:0]  mask_s;

    // Operands are shifted left each cycle, so the current digit is always at the top.
    assign dig_s  = digit_cmp(a_r[WIDTH-1 -: DIGIT], b_r[WIDTH-1 -: DIGIT]);
    assign mask_s = is_signed ? MSB_MASK : {WIDTH{1'b0}};

    // Next-state and next-output logic for the IDLE/RUN controller.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        a_s     = a_r;
        b_s     = b_r;
        ready_s = ready_r;
        done_s  = 1'b0;
        eq_s    = eq_r;
        gt_s    = gt_r;
        lt_s    = lt_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    // Flipping the sign bits lets the unsigned chain order signed values.
                    a_s     = A ^ mask_s;
                    b_s     = B ^ mask_s;
                    eq_s    = 1'b0;
                    gt_s    = 1'b0;
                    lt_s    = 1'b0;
                    cnt_s   = CNT_ZERO;
                    state_s = RUN;
                    ready_s = 1'b0;
                end else begin
                    ready_s = 1'b1;
                end
            end
            RUN: begin
                if (abort) begin
                    state_s = IDLE;
                    ready_s = 1'b1;
                    cnt_s   = CNT_ZERO;
                end else if (!dig_s[1]) begin
                    gt_s    = dig_s[0];
                    lt_s    = ~dig_s[0];
                    eq_s    = 1'b0;
                    done_s  = 1'b1;
                    state_s = IDLE;
                    ready_s = 1'b1;
                    cnt_s   = CNT_ZERO;
                end else if (cnt_r == CNT_LAST) begin
                    eq_s    = 1'b1;
                    done_s  = 1'b1;
                    state_s = IDLE;
                    ready_s = 1'b1;
                    cnt_s   = CNT_ZERO;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                    a_s   = a_r << DIGIT;
                    b_s   = b_r << DIGIT;
                end
            end
            default: begin
                state_s = IDLE;
                ready_s = 1'b1;
                cnt_s   = CNT_ZERO;
                eq_s    = 1'b0;
                gt_s    = 1'b0;
                lt_s    = 1'b0;
            end
        endcase
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
            a_r     <= {WIDTH{1'b0}};
            b_r     <= {WIDTH{1'b0}};
            ready_r <= 1'b1;
            done_r  <= 1'b0;
            eq_r    <= 1'b0;
            gt_r    <= 1'b0;
            lt_r    <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            a_r     <= a_s;
            b_r     <= b_s;
            ready_r <= ready_s;
            done_r  <= done_s;
            eq_r    <= eq_s;
            gt_r    <= gt_s;
            lt_r    <= lt_s;
        end
    end

    assign ready = ready_r;
    assign done  = done_r;
    assign EQ    = eq_r;
    assign GT    = gt_r;
    assign LT    = lt_r;

endmodule

// File: tb/tb_seq_mag_comp.sv
// Directed, table-driven bench for seq_mag_comp (WIDTH=32, DIGIT=2) with
// hand-written back-to-back, abort and asynchronous-reset sequences.
module tb_seq_mag_comp;

    localparam int WIDTH = 32;
    localparam int DIGIT = 2;

    logic             clock;
    logic             reset;
    logic             start;
    logic             abort;
    logic             is_signed;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             ready;
    logic             done;
    logic             EQ;
    logic             GT;
    logic             LT;

    int checks = 0;
    int errors = 0;

    seq_mag_comp #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .is_signed (is_signed),
        .A         (A),
        .B         (B),
        .ready     (ready),
        .done      (done),
        .EQ        (EQ),
        .GT        (GT),
        .LT        (LT)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sgn;
        int          lat;
        logic        eq;
        logic        gt;
        logic        lt;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Advance edge by edge until done; ready must stay low meanwhile.
    task automatic wait_done(output int lat);
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock);
            #1;
            lat++;
            if (done === 1'b1) return;
            chk("ready_low_in_run", {31'd0, ready}, 32'd0);
        end
        chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_cmp(input vec_t v, input string name);
        int lat;
        start     = 1'b1;
        A         = v.a;
        B         = v.b;
        is_signed = v.sgn;
        @(posedge clock);
        #1;
        chk({name, "_accept_ready"}, {31'd0, ready}, 32'd0);
        chk({name, "_accept_flags"}, {29'd0, EQ, GT, LT}, 32'd0);
        start     = 1'b0;
        A         = ~v.a;
        B         = v.b ^ 32'h5A5A_5A5A;
        is_signed = ~v.sgn;
        wait_done(lat);
        chk({name, "_latency"}, lat, v.lat);
        chk({name, "_flags"}, {29'd0, EQ, GT, LT}, {29'd0, v.eq, v.gt, v.lt});
        chk({name, "_ready_at_done"}, {31'd0, ready}, 32'd1);
        @(posedge clock);
        #1;
        chk({name, "_done_one_cycle"}, {31'd0, done}, 32'd0);
        chk({name, "_flags_held"}, {29'd0, EQ, GT, LT}, {29'd0, v.eq, v.gt, v.lt});
    endtask

    initial begin
        int   lat;
        vec_t v;

        vecs[0]  = '{32'h1234_5678, 32'h1234_5678, 1'b0, 16, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{32'h8000_0000, 32'h7FFF_FFFF, 1'b0,  1, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{32'h8000_0000, 32'h7FFF_FFFF, 1'b1,  1, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{32'h0000_0005, 32'h0000_0006, 1'b0, 16, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, 16, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{32'h0000_0000, 32'h0000_0000, 1'b0, 16, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{32'h0001_0000, 32'h0000_0000, 1'b0,  8, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{32'h4000_0000, 32'h0000_0000, 1'b0,  1, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b1,  1, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{32'h0000_0300, 32'h0000_0200, 1'b0, 12, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{32'h0000_0003, 32'h0000_0001, 1'b1, 16, 1'b0, 1'b1, 1'b0};

        reset     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        is_signed = 1'b0;
        A         = 32'd0;
        B         = 32'd0;
        #12;
        chk("reset_ready", {31'd0, ready}, 32'd1);
        chk("reset_done_flags", {28'd0, done, EQ, GT, LT}, 32'd0);
        reset = 1'b1;
        @(posedge clock);
        #1;

        for (int i = 0; i < 11; i++) begin
            run_cmp(vecs[i], $sformatf("vec%0d", i));
        end

        // Back-to-back: start held high through done, operands changed mid-run.
        start     = 1'b1;
        is_signed = 1'b0;
        A         = 32'h1234_5678;
        B         = 32'h1234_5679;
        @(posedge clock);
        #1;
        A = 32'd3;
        B = 32'd1;
        wait_done(lat);
        chk("b2b_first_latency", lat, 32'd16);
        chk("b2b_first_flags", {29'd0, EQ, GT, LT}, 32'b001);
        chk("b2b_ready_on_done", {31'd0, ready}, 32'd1);
        @(posedge clock);
        #1;
        chk("b2b_second_accepted", {30'd0, ready, done}, 32'd0);
        chk("b2b_second_cleared", {29'd0, EQ, GT, LT}, 32'd0);
        start = 1'b0;
        wait_done(lat);
        chk("b2b_second_latency", lat, 32'd16);
        chk("b2b_second_flags", {29'd0, EQ, GT, LT}, 32'b010);
        @(posedge clock);
        #1;

        // Abort four cycles into an equal-operand compare.
        start = 1'b1;
        A     = 32'hAAAA_AAAA;
        B     = 32'hAAAA_AAAA;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        abort = 1'b1;
        @(posedge clock);
        #1;
        chk("abort_no_done", {31'd0, done}, 32'd0);
        chk("abort_ready", {31'd0, ready}, 32'd1);
        chk("abort_flags", {29'd0, EQ, GT, LT}, 32'd0);
        abort = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(posedge clock);
            #1;
            chk("abort_stays_idle", {30'd0, done, ready}, 32'd1);
        end
        v = '{32'h0000_0000, 32'h0000_0000, 1'b0, 16, 1'b1, 1'b0, 1'b0};
        run_cmp(v, "after_abort");

        // Abort on the same edge a first-digit decision would fire.
        start = 1'b1;
        A     = 32'h8000_0000;
        B     = 32'h0000_0000;
        @(posedge clock);
        #1;
        start = 1'b0;
        abort = 1'b1;
        @(posedge clock);
        #1;
        chk("abort_wins_decide", {28'd0, done, EQ, GT, LT}, 32'd0);
        chk("abort_wins_ready", {31'd0, ready}, 32'd1);
        abort = 1'b0;
        @(posedge clock);
        #1;
        chk("abort_wins_no_late_done", {31'd0, done}, 32'd0);

        // start and abort together in IDLE: start wins.
        start = 1'b1;
        abort = 1'b1;
        A     = 32'd1;
        B     = 32'd0;
        @(posedge clock);
        #1;
        chk("start_beats_abort", {31'd0, ready}, 32'd0);
        start = 1'b0;
        abort = 1'b0;
        wait_done(lat);
        chk("start_beats_abort_latency", lat, 32'd16);
        chk("start_beats_abort_flags", {29'd0, EQ, GT, LT}, 32'b010);
        abort = 1'b1;
        @(posedge clock);
        #1;
        chk("abort_idle_no_effect", {28'd0, ready, EQ, GT, LT}, 32'b1010);
        abort = 1'b0;

        // Asynchronous reset between edges in the middle of a compare.
        start = 1'b1;
        A     = 32'h5555_5555;
        B     = 32'h5555_5555;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clock);
        #3;
        reset = 1'b0;
        #1;
        chk("async_reset_ready", {31'd0, ready}, 32'd1);
        chk("async_reset_outputs", {28'd0, done, EQ, GT, LT}, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(posedge clock);
            #1;
            chk("reset_discards_op", {31'd0, done}, 32'd0);
        end
        v = '{32'd9, 32'd9, 1'b0, 16, 1'b1, 1'b0, 1'b0};
        run_cmp(v, "after_reset");
        #2;
        reset = 1'b0;
        #1;
        chk("reset_clears_held_eq", {28'd0, ready, EQ, GT, LT}, 32'b1000);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_mag_comp.md
Name: seq_mag_comp

Overview:
- Multi-cycle, parametrised magnitude comparator for the ALU comparator family.
- Compares two WIDTH-bit operands MSB-first, DIGIT bits per cycle, using the cascaded EQ/GT digit chain, and stops as soon as a digit differs.
- Supports unsigned and two's-complement signed modes.
- Uses a start/ready/done handshake and an abort input.
- Feeds the branch-compare and slt paths when a single-cycle wide comparator does not meet timing.

Parameters:
- WIDTH, 32, operand width in bits; must be a multiple of DIGIT.
- DIGIT, 2, bits compared per cycle; legal values 1, 2, 4, 8.

Ports:
- clock  input  1  single clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request a compare; honoured only when ready=1.
- abort  input  1  cancels an in-flight compare.
- is_signed  input  1  1 = two's-complement compare, 0 = unsigned; sampled with start.
- A  input  WIDTH  operand A; sampled with start.
- B  input  WIDTH  operand B; sampled with start.
- ready  output  1  block can accept start.
- done  output  1  one-cycle pulse: result valid.
- EQ  output  1  A == B.
- GT  output  1  A > B.
- LT  output  1  A < B.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, ready=1, done=0, EQ=0, GT=0, LT=0, digit counter=0.
  - Reset asserted mid-compare discards the operation; no done pulse.
- N = WIDTH/DIGIT digits, indexed k=0..N-1. Digit k covers bits [WIDTH-1-k*DIGIT : WIDTH-DIGIT-k*DIGIT].
- States: IDLE, RUN.
- IDLE:
  - ready=1.
  - start=1 at edge E0: latch A, B and mode; clear EQ/GT/LT; k=0; go to RUN.
  - Signed mode: invert bit WIDTH-1 of both latched operands at capture. The unsigned datapath then yields the signed result.
- RUN:
  - ready=0; start is ignored (no queueing).
  - Each edge E(k+1) evaluates digit k.
  - Digit differs: set GT or LT per that digit, EQ=0, pulse done, go to IDLE.
  - Digit equal and k<N-1: k=k+1, stay in RUN.
  - Digit equal and k=N-1: EQ=1, pulse done, go to IDLE.
- Latency:
  - Result and done are visible in the cycle after edge E(d), where d = index of the deciding digit + 1.
  - Minimum latency 1 cycle; maximum N cycles (equal operands, or difference only in the last digit).
- Result holding:
  - done is high for exactly one cycle.
  - EQ/GT/LT hold their values until the next accepted start clears them.
  - Exactly one of EQ/GT/LT is 1 after any done; all three are 0 while RUN.
- Back-to-back: start may be asserted in the same cycle done=1. ready=1 then, since the state is already IDLE, and the new compare begins at that edge.
- abort:
  - abort=1 in RUN: go to IDLE at the next edge, no done, flags remain 0.
  - abort in IDLE has no effect.
  - abort and start both high in IDLE: start wins.
  - abort in the same edge a digit decides: abort wins; no done, flags 0.
- Operand inputs may change freely after acceptance; only the latched copies are used.
- Counter k never wraps; leaving RUN resets k to 0.

Test Plan:
- WIDTH=32, DIGIT=2, unsigned, A=B=0x12345678 -> done exactly 16 cycles after the accept edge; EQ=1, GT=0, LT=0; ready=0 during those cycles.
- A=0x80000000, B=0x7FFFFFFF, is_signed=0 -> done after 1 cycle, GT=1. Same operands with is_signed=1 -> done after 1 cycle, LT=1.
- A=5, B=6, unsigned -> digits 0..14 equal, digit 15 compares 01 vs 10 -> done at cycle 16, LT=1. Then A=0xFFFFFFFF, B=0xFFFFFFFE signed -> done at 16, GT=1.
- Back-to-back: start held high across a done pulse with new operands A=3, B=1 -> second compare accepted on the done cycle. Mid-RUN start pulses are ignored; ready is never high during RUN.
- abort asserted 4 cycles into a compare of equal operands -> no done, flags 0, ready=1 next cycle. A subsequent start with A=B=0 -> EQ=1 after 16 cycles.
- reset driven low asynchronously mid-RUN (between edges) -> ready=1 and done/EQ/GT/LT=0 immediately. After release, a fresh compare A=9, B=9 completes normally.
